fp_add_sub_pipe: RTL and testbench

FP_ADD_SUB_PIPE -- requirements
Module: fp_add_sub_pipe

---
 rtl/fp_add_sub_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_fp_add_sub_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe: three-stage pipelined floating-point add/subtract with round-to-nearest-even.
// Build macro FP_ADD_SUB_EXC_EN: decode the all-ones exponent as Inf/NaN instead of a finite value.
module fp_add_sub_pipe #(
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MANT_BITS = 23
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_BITS+MANT_BITS:0]   a,
  input  logic [EXP_BITS+MANT_BITS:0]   b,
  input  logic                          operation_select,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_BITS+MANT_BITS:0]   result,
  output logic [3:0]                    flags
);
  localparam int unsigned WIDTH = 1 + EXP_BITS + MANT_BITS;
  localparam int unsigned AW    = MANT_BITS + 4;   // hidden, fraction, G, R, S
  localparam int unsigned SW    = AW + 1;          // plus carry
  localparam int unsigned XW    = EXP_BITS + 2;    // signed exponent with headroom
  localparam int unsigned LW    = $clog2(SW);
  localparam int unsigned MW    = MANT_BITS + 2;   // rounded mantissa with overflow bit
  localparam logic [EXP_BITS-1:0]        EXP_ONES = '1;
  localparam logic signed [XW-1:0]       EXP_OVF  = signed'(XW'(EXP_ONES));

  // Whole pipeline advances together unless a held result is blocking the output
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- Stage 1: unpack, compare, swap, align ----------------
  logic                 sign_a, sign_b, zero_a, zero_b, a_big, sign_big, sign_sml;
  logic [EXP_BITS-1:0]  exp_a, exp_b, exp_big, exp_sml, exp_diff, shamt;
  logic [MANT_BITS-1:0] frac_a, frac_b;
  logic [AW-1:0]        mant_big, mant_sml, aligned;
  logic [2*AW-1:0]      shifted;
`ifdef FP_ADD_SUB_EXC_EN
  logic nan_a, nan_b, inf_a, inf_b;
  logic s1_nan, s1_inf, s1_isign, s2_nan, s2_inf, s2_isign;
`endif

  // Operand decode, magnitude ordering and sticky-preserving alignment
  always_comb begin
    sign_a   = a[WIDTH-1];
    sign_b   = b[WIDTH-1] ^ operation_select;
    exp_a    = a[WIDTH-2 -: EXP_BITS];
    exp_b    = b[WIDTH-2 -: EXP_BITS];
    zero_a   = (exp_a == '0);
    zero_b   = (exp_b == '0);
    frac_a   = zero_a ? '0 : a[MANT_BITS-1:0];
    frac_b   = zero_b ? '0 : b[MANT_BITS-1:0];
    a_big    = {exp_a, frac_a} >= {exp_b, frac_b};
    sign_big = a_big ? sign_a : sign_b;
    sign_sml = a_big ? sign_b : sign_a;
    exp_big  = a_big ? exp_a : exp_b;
    exp_sml  = a_big ? exp_b : exp_a;
    mant_big = a_big ? {~zero_a, frac_a, 3'b000} : {~zero_b, frac_b, 3'b000};
    mant_sml = a_big ? {~zero_b, frac_b, 3'b000} : {~zero_a, frac_a, 3'b000};
    exp_diff = exp_big - exp_sml;
    shamt    = (exp_diff > EXP_BITS'(AW)) ? EXP_BITS'(AW) : exp_diff;
    shifted  = {mant_sml, {AW{1'b0}}} >> shamt;
    aligned  = {shifted[2*AW-1:AW+1], shifted[AW] | (|shifted[AW-1:0])};
`ifdef FP_ADD_SUB_EXC_EN
    nan_a    = (exp_a == EXP_ONES) && (frac_a != '0);
    nan_b    = (exp_b == EXP_ONES) && (frac_b != '0);
    inf_a    = (exp_a == EXP_ONES) && (frac_a == '0);
    inf_b    = (exp_b == EXP_ONES) && (frac_b == '0);
`endif
  end

  logic                s1_valid, s1_sign, s1_sub, s1_zz;
  logic [EXP_BITS-1:0] s1_exp;
  logic [AW-1:0]       s1_mb, s1_ms;

  // Stage 1 register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_zz    <= 1'b0;
      s1_exp   <= '0;
      s1_mb    <= '0;
      s1_ms    <= '0;
`ifdef FP_ADD_SUB_EXC_EN
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_isign <= 1'b0;
`endif
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= (zero_a && zero_b) ? (sign_a & sign_b) : sign_big;
      s1_sub   <= sign_big ^ sign_sml;
      s1_zz    <= zero_a && zero_b;
      s1_exp   <= exp_big;
      s1_mb    <= mant_big;
      s1_ms    <= aligned;
`ifdef FP_ADD_SUB_EXC_EN
      s1_nan   <= nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b));
      s1_inf   <= inf_a || inf_b;
      s1_isign <= inf_a ? sign_a : sign_b;
`endif
    end
  end

  // ---------------- Stage 2: magnitude add/subtract ----------------
  logic                s2_valid, s2_sign, s2_zz;
  logic [EXP_BITS-1:0] s2_exp;
  logic [SW-1:0]       s2_sum;

  // Stage 2 register; base magnitude is never smaller, so the difference is non-negative
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zz    <= 1'b0;
      s2_exp   <= '0;
      s2_sum   <= '0;
`ifdef FP_ADD_SUB_EXC_EN
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_isign <= 1'b0;
`endif
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zz    <= s1_zz;
      s2_exp   <= s1_exp;
      s2_sum   <= s1_sub ? ({1'b0, s1_mb} - {1'b0, s1_ms}) : ({1'b0, s1_mb} + {1'b0, s1_ms});
`ifdef FP_ADD_SUB_EXC_EN
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_isign <= s1_isign;
`endif
    end
  end

  // ---------------- Stage 3: normalise, round, pack ----------------
  logic                   found, rnd_up, inexact;
  logic [LW-1:0]          lz;
  logic [AW-1:0]          norm;
  logic signed [XW-1:0]   exp_n, exp_f;
  logic [MW-1:0]          mant_r;
  logic [MANT_BITS-1:0]   frac_f;
  logic [WIDTH-1:0]       res_c;
  logic [3:0]             flg_c;

  // Leading-zero normalisation, RNE rounding and special-case selection
  always_comb begin
    found = 1'b0;
    lz    = '0;
    for (int i = AW - 1; i >= 0; i--) begin
      if (!found && s2_sum[i]) begin
        found = 1'b1;
        lz    = LW'(AW - 1 - i);
      end
    end
    if (s2_sum[AW]) begin
      norm  = {s2_sum[AW:2], s2_sum[1] | s2_sum[0]};
      exp_n = XW'(s2_exp) + XW'(1);
    end else begin
      norm  = s2_sum[AW-1:0] << lz;
      exp_n = XW'(s2_exp) - XW'(lz);
    end
    inexact = |norm[2:0];
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r  = {1'b0, norm[AW-1:3]} + MW'(rnd_up);
    exp_f   = exp_n + XW'(mant_r[MANT_BITS+1]);
    frac_f  = mant_r[MANT_BITS+1] ? mant_r[MANT_BITS:1] : mant_r[MANT_BITS-1:0];
    res_c   = {s2_sign, exp_f[EXP_BITS-1:0], frac_f};
    flg_c   = {3'b000, inexact};
    if (s2_sum == '0) begin
      res_c = {s2_zz & s2_sign, {(WIDTH-1){1'b0}}};
      flg_c = 4'b0000;
    end else if (exp_f[XW-1] || exp_f == '0) begin
      res_c = {s2_sign, {(WIDTH-1){1'b0}}};
      flg_c = 4'b0011;
    end else if (exp_f >= EXP_OVF) begin
`ifdef FP_ADD_SUB_EXC_EN
      res_c = {s2_sign, EXP_ONES, {MANT_BITS{1'b0}}};
`else
      res_c = {s2_sign, EXP_ONES, {MANT_BITS{1'b1}}};
`endif
      flg_c = 4'b0101;
    end
`ifdef FP_ADD_SUB_EXC_EN
    if (s2_nan) begin
      res_c = {1'b0, EXP_ONES, 1'b1, {(MANT_BITS-1){1'b0}}};
      flg_c = 4'b1000;
    end else if (s2_inf) begin
      res_c = {s2_isign, EXP_ONES, {MANT_BITS{1'b0}}};
      flg_c = 4'b0000;
    end
`endif
  end

  // Output register; held while the consumer stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= res_c;
        flags  <= flg_c;
      end
    end
  end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// tb_fp_add_sub_pipe: directed scoreboard bench for fp_add_sub_pipe at default parameters.
module tb_fp_add_sub_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        operation_select;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_add_sub_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .operation_select(operation_select),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc;
    bit          lat;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_in  = 0;
  int n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Output monitor: compares transfers against the scoreboard, and held outputs during stalls
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (out_ready) begin
        total++;
        assert (sb_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_output observed=%h expected=none", result);
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          n_out++;
          check($sformatf("result[%0d]", e.id), result, e.res);
          check($sformatf("flags[%0d]", e.id), 32'(flags), 32'(e.flg));
          if (e.lat) check($sformatf("latency[%0d]", e.id), 32'(cyc - e.acc), 32'd3);
        end
      end else begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        if (sb_q.size() != 0) begin
          check($sformatf("held_result[%0d]", sb_q[0].id), result, sb_q[0].res);
          check($sformatf("held_flags[%0d]", sb_q[0].id), 32'(flags), 32'(sb_q[0].flg));
        end
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic op,
                      input logic [31:0] er, input logic [3:0] ef, input bit lat);
    int w = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    operation_select = op;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("accept", 32'(in_ready), 32'd1);
    if (in_ready) begin
      sb_q.push_back('{er, ef, cyc, lat, n_in});
      n_in++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 60) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    operation_select = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed vectors, back-to-back with latency checked
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 1'b1);
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1'b1);
    send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 1'b1);
`ifdef FP_ADD_SUB_EXC_EN
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1'b1);
    send(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 4'b0101, 1'b1);
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000, 1'b1);
`else
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7FFFFFFF, 4'b0101, 1'b1);
    send(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFFFFFFFF, 4'b0101, 1'b1);
`endif
    send(32'h40A00000, 32'h40000000, 1'b1, 32'h40400000, 4'b0000, 1'b1);
    send(32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'b0000, 1'b1);
    send(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000, 1'b1);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1'b1);
    send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 1'b1);
    send(32'h40400000, 32'h00000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
    send(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 1'b1);
    send(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011, 1'b1);
    send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 1'b1);
    send(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001, 1'b1);
    send(32'h3F800000, 32'h00800000, 1'b1, 32'h3F800000, 4'b0001, 1'b1);
    send(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001, 1'b1);
    send(32'h3F800000, 32'hB3800000, 1'b0, 32'h3F7FFFFF, 4'b0000, 1'b1);
    drain();

    // Eight back-to-back operations with the consumer stalled for cycles 4-6
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 1'b0);
        send(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 4'b0000, 1'b0);
        send(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 4'b0000, 1'b0);
        send(32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 4'b0000, 1'b0);
        send(32'h40A00000, 32'h40000000, 1'b0, 32'h40E00000, 4'b0000, 1'b0);
        send(32'h40C00000, 32'h41000000, 1'b1, 32'hC0000000, 4'b0000, 1'b0);
        send(32'hC0400000, 32'hC0400000, 1'b0, 32'hC0C00000, 4'b0000, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("count_in_out", 32'(n_out), 32'(n_in));

    // Reset with three operations in flight
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b1);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 1'b1);
    send(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 4'b0000, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    n_in = n_in - sb_q.size();
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_output", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b1);
    drain();
    check("final_count", 32'(n_out), 32'(n_in));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
